// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : cpu_run_ctrl
// Brief   : Run controller for the five-stage cache CPU. Holds the core in
//           reset while the boot PC is presented, then supervises execution
//           until an ecall halt, a cycle-budget timeout or a PC stall. Keeps
//           run-cycle and retired-instruction counts and a completion status.
// Revision: 1.0 - initial release
// ============================================================================
module cpu_run_ctrl #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] BOOT_PC      = '0,
  parameter int              RESET_CYCLES = 4,
  parameter int              MAX_CYCLES   = 1280,
  parameter int              STALL_LIMIT  = 16,
  parameter logic [XLEN-1:0] HALT_INSN    = 32'h00000073,
  parameter int              CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [XLEN-1:0]  insn_i,
  input  logic             insn_valid_i,
  output logic             core_rst_o,
  output logic             pc_load_o,
  output logic [XLEN-1:0]  boot_pc_o,
  output logic             running_o,
  output logic             done_o,
  output logic [1:0]       status_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] retire_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RESET = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] c_stat_none    = 2'd0;
  localparam logic [1:0] c_stat_halt    = 2'd1;
  localparam logic [1:0] c_stat_timeout = 2'd2;
  localparam logic [1:0] c_stat_stall   = 2'd3;

  // Reset-phase counter only needs to reach RESET_CYCLES-1.
  localparam int               c_rst_w      = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [c_rst_w-1:0] c_rst_last = c_rst_w'(RESET_CYCLES - 1);

  localparam logic [CNT_W-1:0] c_cnt_max    = '1;
  // "count+1 would reach LIMIT" is the same as "count == LIMIT-1".
  localparam logic [CNT_W-1:0] c_cycle_last = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_stall_last = CNT_W'(STALL_LIMIT - 1);
  localparam bit               c_timeout_en = (MAX_CYCLES != 0);
  localparam bit               c_stall_en   = (STALL_LIMIT != 0);

  state_t             r_state;
  state_t             w_next;
  logic [c_rst_w-1:0] r_rst_cnt;
  logic [CNT_W-1:0]   r_cycle_cnt;
  logic [CNT_W-1:0]   r_retire_cnt;
  logic [CNT_W-1:0]   r_stall_cnt;
  logic [XLEN-1:0]    r_pc_prev;
  logic [1:0]         r_status;

  logic               w_same_pc;
  logic               w_halt;
  logic               w_stall;
  logic               w_timeout;
  logic               w_end;
  logic [1:0]         w_end_status;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == c_cnt_max) ? v : v + 1'b1;
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state, end-condition priority and state-decoded outputs.
  always_comb begin
    w_next       = r_state;
    w_same_pc    = (pc_i == r_pc_prev);
    w_halt       = insn_valid_i && (insn_i == HALT_INSN);
    w_stall      = c_stall_en && w_same_pc && (r_stall_cnt == c_stall_last);
    w_timeout    = c_timeout_en && (r_cycle_cnt == c_cycle_last);
    w_end        = w_halt || w_stall || w_timeout;
    w_end_status = c_stat_timeout;
    core_rst_o   = 1'b1;
    pc_load_o    = 1'b0;
    running_o    = 1'b0;
    done_o       = 1'b0;

    if (w_halt) begin
      w_end_status = c_stat_halt;
    end else if (w_stall) begin
      w_end_status = c_stat_stall;
    end

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = S_RESET;
        end
      end
      S_RESET: begin
        pc_load_o = 1'b1;
        if (r_rst_cnt == c_rst_last) begin
          w_next = S_RUN;
        end
      end
      S_RUN: begin
        core_rst_o = 1'b0;
        running_o  = 1'b1;
        if (w_end) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        done_o = 1'b1;
        if (start) begin
          w_next = S_RESET;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase

    // abort beats start and any end condition seen in the same cycle.
    if (abort) begin
      w_next = S_IDLE;
    end
  end

  // Reset-phase counter, run counters, PC history and status latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rst_cnt    <= '0;
      r_cycle_cnt  <= '0;
      r_retire_cnt <= '0;
      r_stall_cnt  <= '0;
      r_pc_prev    <= '0;
      r_status     <= c_stat_none;
    end else if (abort) begin
      // Counters stay readable after an abort; only the status is dropped.
      r_status <= c_stat_none;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_rst_cnt <= '0;
          end
        end
        S_RESET: begin
          if (r_rst_cnt == c_rst_last) begin
            r_cycle_cnt  <= '0;
            r_retire_cnt <= '0;
            r_stall_cnt  <= '0;
            r_status     <= c_stat_none;
            r_pc_prev    <= pc_i;
          end else begin
            r_rst_cnt <= r_rst_cnt + 1'b1;
          end
        end
        S_RUN: begin
          r_cycle_cnt <= sat_inc(r_cycle_cnt);
          if (insn_valid_i) begin
            r_retire_cnt <= sat_inc(r_retire_cnt);
          end
          r_stall_cnt <= w_same_pc ? sat_inc(r_stall_cnt) : '0;
          r_pc_prev   <= pc_i;
          if (w_end) begin
            r_status <= w_end_status;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign boot_pc_o    = BOOT_PC;
  assign status_o     = r_status;
  assign cycle_cnt_o  = r_cycle_cnt;
  assign retire_cnt_o = r_retire_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_cpu_run_ctrl
// Brief   : Self-checking bench for cpu_run_ctrl. A phase-level model of the
//           run sequence is stepped once per clock and every output is
//           compared against it each cycle; literal expectations pin the
//           headline numbers of each scenario.
// Revision: 1.0 - initial release
// ============================================================================
module tb_cpu_run_ctrl;

  localparam int          RST_CYC = 4;
  localparam int          MAXC    = 1280;
  localparam int          STL     = 16;
  localparam logic [31:0] HALT    = 32'h00000073;
  localparam logic [31:0] NOP     = 32'h00000013;
  localparam longint      CSAT    = 64'h0000_0000_FFFF_FFFF;

  // Model phases (run sequence as seen from outside)
  localparam int M_IDLE = 0;
  localparam int M_BOOT = 1;
  localparam int M_EXEC = 2;
  localparam int M_FIN  = 3;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [31:0] pc_i;
  logic [31:0] insn_i;
  logic        insn_valid_i;
  logic        core_rst_o;
  logic        pc_load_o;
  logic [31:0] boot_pc_o;
  logic        running_o;
  logic        done_o;
  logic [1:0]  status_o;
  logic [31:0] cycle_cnt_o;
  logic [31:0] retire_cnt_o;

  cpu_run_ctrl #(
    .XLEN        (32),
    .BOOT_PC     (32'h0),
    .RESET_CYCLES(RST_CYC),
    .MAX_CYCLES  (MAXC),
    .STALL_LIMIT (STL),
    .HALT_INSN   (HALT),
    .CNT_W       (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .pc_i        (pc_i),
    .insn_i      (insn_i),
    .insn_valid_i(insn_valid_i),
    .core_rst_o  (core_rst_o),
    .pc_load_o   (pc_load_o),
    .boot_pc_o   (boot_pc_o),
    .running_o   (running_o),
    .done_o      (done_o),
    .status_o    (status_o),
    .cycle_cnt_o (cycle_cnt_o),
    .retire_cnt_o(retire_cnt_o)
  );

  int          n_vec  = 0;
  int          n_bad  = 0;
  bit          chk_en = 0;

  // Inputs to apply on the next cycle
  logic        nx_rst;
  logic        nx_start;
  logic        nx_abort;
  logic        nx_valid;
  logic [31:0] nx_pc;
  logic [31:0] nx_insn;

  // Model state
  int          m_phase;
  int          m_boot_left;
  int          m_same;
  int          m_stat;
  longint      m_cyc;
  longint      m_ret;
  logic [31:0] m_prev;

  int          n_rst;
  int          n_ld;
  int          n_run;

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net in case the DUT wedges in a way no bounded loop catches
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Advance the model by one rising edge using the inputs just applied
  task automatic model_step();
    if (rst) begin
      m_phase = M_IDLE;
      m_cyc   = 0;
      m_ret   = 0;
      m_stat  = 0;
      m_same  = 0;
      m_prev  = '0;
    end else if (abort) begin
      m_phase = M_IDLE;
      m_stat  = 0;
    end else begin
      case (m_phase)
        M_IDLE, M_FIN: begin
          if (start) begin
            m_phase     = M_BOOT;
            m_boot_left = RST_CYC;
          end
        end
        M_BOOT: begin
          m_boot_left--;
          if (m_boot_left == 0) begin
            m_phase = M_EXEC;
            m_cyc   = 0;
            m_ret   = 0;
            m_same  = 0;
            m_stat  = 0;
            m_prev  = pc_i;
          end
        end
        M_EXEC: begin
          m_cyc = (m_cyc < CSAT) ? m_cyc + 1 : m_cyc;
          if (insn_valid_i) m_ret = (m_ret < CSAT) ? m_ret + 1 : m_ret;
          m_same = (pc_i == m_prev) ? m_same + 1 : 0;
          m_prev = pc_i;
          if (insn_valid_i && insn_i == HALT) begin
            m_stat  = 1;
            m_phase = M_FIN;
          end else if (STL != 0 && m_same >= STL) begin
            m_stat  = 3;
            m_phase = M_FIN;
          end else if (MAXC != 0 && m_cyc >= MAXC) begin
            m_stat  = 2;
            m_phase = M_FIN;
          end
        end
        default: m_phase = M_IDLE;
      endcase
    end
  endtask

  // Per-cycle comparison of every output against the model
  task automatic compare_cycle();
    chk("core_rst_o",   64'(core_rst_o),   64'(m_phase != M_EXEC));
    chk("pc_load_o",    64'(pc_load_o),    64'(m_phase == M_BOOT));
    chk("boot_pc_o",    64'(boot_pc_o),    64'(32'h0));
    chk("running_o",    64'(running_o),    64'(m_phase == M_EXEC));
    chk("done_o",       64'(done_o),       64'(m_phase == M_FIN));
    chk("status_o",     64'(status_o),     64'(m_stat));
    chk("cycle_cnt_o",  64'(cycle_cnt_o),  64'(m_cyc));
    chk("retire_cnt_o", 64'(retire_cnt_o), 64'(m_ret));
  endtask

  // One clock: check outputs, apply next inputs, step the model
  task automatic cyc();
    @(negedge clk);
    if (chk_en) compare_cycle();
    rst          = nx_rst;
    start        = nx_start;
    abort        = nx_abort;
    pc_i         = nx_pc;
    insn_i       = nx_insn;
    insn_valid_i = nx_valid;
    model_step();
    chk_en = 1'b1;
  endtask

  // Pulse start and wait (bounded) until the core leaves reset
  task automatic launch(input logic [31:0] pc_step, output int c_rst, output int c_ld);
    c_rst    = 0;
    c_ld     = 0;
    nx_start = 1'b1;
    cyc();
    nx_start = 1'b0;
    for (int i = 0; i < 32 && core_rst_o; i++) begin
      c_rst++;
      if (pc_load_o) c_ld++;
      nx_pc = nx_pc + pc_step;
      cyc();
    end
    chk("run_entered", 64'(running_o), 64'd1);
  endtask

  // Run (bounded) until done_o, counting cycles with running_o high
  task automatic run_to_done(input logic [31:0] pc_step, input int budget, output int c_run);
    c_run = 0;
    for (int i = 0; i < budget && !done_o; i++) begin
      if (running_o) c_run++;
      nx_pc = nx_pc + pc_step;
      cyc();
    end
    chk("done_reached", 64'(done_o), 64'd1);
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    abort        = 1'b0;
    pc_i         = '0;
    insn_i       = '0;
    insn_valid_i = 1'b0;
    nx_rst       = 1'b1;
    nx_start     = 1'b0;
    nx_abort     = 1'b0;
    nx_valid     = 1'b0;
    nx_pc        = '0;
    nx_insn      = NOP;

    // Reset held for two cycles
    cyc();
    cyc();
    nx_rst = 1'b0;
    cyc();
    chk("rst_core_rst", 64'(core_rst_o),  64'd1);
    chk("rst_running",  64'(running_o),   64'd0);
    chk("rst_status",   64'(status_o),    64'd0);
    chk("rst_cycle",    64'(cycle_cnt_o), 64'd0);
    chk("rst_boot_pc",  64'(boot_pc_o),   64'd0);

    // Timeout run: PC advances by 4 every cycle, nothing retires
    nx_pc = 32'h100;
    launch(32'd4, n_rst, n_ld);
    chk("start_to_run_latency", 64'(n_rst), 64'd5);
    chk("pc_load_cycles",       64'(n_ld),  64'd4);
    run_to_done(32'd4, 2000, n_run);
    chk("timeout_run_cycles", 64'(n_run),        64'd1280);
    chk("timeout_status",     64'(status_o),     64'd2);
    chk("timeout_cycle_cnt",  64'(cycle_cnt_o),  64'd1280);
    chk("timeout_retire_cnt", 64'(retire_cnt_o), 64'd0);

    // Restart from DONE, then halt on the 10th retired instruction
    nx_start = 1'b1;
    cyc();
    nx_start = 1'b0;
    chk("done_counters_frozen", 64'(cycle_cnt_o), 64'd1280);
    for (int i = 0; i < 32 && core_rst_o; i++) begin
      nx_pc = nx_pc + 32'd4;
      cyc();
    end
    chk("restart_running",    64'(running_o),    64'd1);
    chk("restart_cycle_zero", 64'(cycle_cnt_o),  64'd0);
    chk("restart_retire_zero",64'(retire_cnt_o), 64'd0);
    chk("restart_status_zero",64'(status_o),     64'd0);
    for (int k = 1; k <= 10; k++) begin
      nx_pc    = nx_pc + 32'd4;
      nx_valid = 1'b1;
      nx_insn  = (k == 10) ? HALT : NOP;
      cyc();
    end
    chk("halt_done_not_same_cycle", 64'(done_o), 64'd0);
    nx_valid = 1'b0;
    nx_insn  = NOP;
    nx_pc    = nx_pc + 32'd4;
    cyc();
    chk("halt_done_next_cycle", 64'(done_o),       64'd1);
    chk("halt_status",          64'(status_o),     64'd1);
    chk("halt_retire_cnt",      64'(retire_cnt_o), 64'd10);
    chk("halt_cycle_cnt",       64'(cycle_cnt_o),  64'd11);

    // Stall: PC pinned at 0x40 from before RUN entry
    nx_pc = 32'h40;
    launch(32'd0, n_rst, n_ld);
    run_to_done(32'd0, 100, n_run);
    chk("stall_run_cycles", 64'(n_run),        64'd16);
    chk("stall_status",     64'(status_o),     64'd3);
    chk("stall_cycle_cnt",  64'(cycle_cnt_o),  64'd16);
    chk("stall_retire_cnt", 64'(retire_cnt_o), 64'd0);

    // HALT and TIMEOUT on the same (1280th) RUN cycle: HALT wins
    nx_pc = 32'h1000;
    launch(32'd4, n_rst, n_ld);
    for (int k = 2; k <= MAXC; k++) begin
      nx_pc    = nx_pc + 32'd4;
      nx_valid = (k == MAXC);
      nx_insn  = HALT;
      cyc();
    end
    nx_valid = 1'b0;
    nx_insn  = NOP;
    nx_pc    = nx_pc + 32'd4;
    cyc();
    chk("collide_status",     64'(status_o),     64'd1);
    chk("collide_cycle_cnt",  64'(cycle_cnt_o),  64'd1280);
    chk("collide_retire_cnt", 64'(retire_cnt_o), 64'd1);

    // abort together with start in DONE: back to IDLE, counters held
    nx_abort = 1'b1;
    nx_start = 1'b1;
    cyc();
    nx_abort = 1'b0;
    nx_start = 1'b0;
    cyc();
    chk("abort_start_status",  64'(status_o),    64'd0);
    chk("abort_start_done",    64'(done_o),      64'd0);
    chk("abort_start_core_rst",64'(core_rst_o),  64'd1);
    chk("abort_start_pc_load", 64'(pc_load_o),   64'd0);
    chk("abort_start_cnt_held",64'(cycle_cnt_o), 64'd1280);

    // abort in the middle of a run
    launch(32'd4, n_rst, n_ld);
    repeat (3) begin
      nx_pc = nx_pc + 32'd4;
      cyc();
    end
    nx_abort = 1'b1;
    nx_pc    = nx_pc + 32'd4;
    cyc();
    nx_abort = 1'b0;
    cyc();
    chk("abort_run_running", 64'(running_o),   64'd0);
    chk("abort_run_cnt",     64'(cycle_cnt_o), 64'd4);
    chk("abort_run_status",  64'(status_o),    64'd0);

    // rst in the middle of a run, with start also high
    launch(32'd4, n_rst, n_ld);
    repeat (4) begin
      nx_pc = nx_pc + 32'd4;
      cyc();
    end
    nx_rst   = 1'b1;
    nx_start = 1'b1;
    cyc();
    nx_rst   = 1'b0;
    nx_start = 1'b0;
    cyc();
    chk("midrst_core_rst", 64'(core_rst_o),   64'd1);
    chk("midrst_running",  64'(running_o),    64'd0);
    chk("midrst_pc_load",  64'(pc_load_o),    64'd0);
    chk("midrst_cycle",    64'(cycle_cnt_o),  64'd0);
    chk("midrst_retire",   64'(retire_cnt_o), 64'd0);

    // A fresh run after reset completes on an immediate halt
    launch(32'd4, n_rst, n_ld);
    nx_valid = 1'b1;
    nx_insn  = HALT;
    nx_pc    = nx_pc + 32'd4;
    cyc();
    nx_valid = 1'b0;
    nx_insn  = NOP;
    cyc();
    chk("rerun_done",   64'(done_o),       64'd1);
    chk("rerun_status", 64'(status_o),     64'd1);
    chk("rerun_retire", 64'(retire_cnt_o), 64'd1);
    chk("rerun_cycle",  64'(cycle_cnt_o),  64'd2);

    cyc();
    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
